// File: rtl/acc_pkg.sv
// Shared types and opcode map for the accumulator sequencer and its decoder.
package acc_pkg;

  localparam int unsigned INSTR_W = 9;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, HALT} state_t;

  // R-type opcodes, instr[7:4]
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_MVFR  = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_STR   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_MOV   = 4'd10;
  localparam logic [3:0] OP_BTRU  = 4'd11;
  localparam logic [3:0] OP_CMP   = 4'd12;
  localparam logic [3:0] OP_NOT   = 4'd13;

  // I-type opcodes, instr[7:5]; 0 and 6 are NOPs
  localparam logic [2:0] IOP_ADDI = 3'd1;
  localparam logic [2:0] IOP_SUBI = 3'd2;
  localparam logic [2:0] IOP_B    = 3'd3;
  localparam logic [2:0] IOP_ANDI = 3'd4;
  localparam logic [2:0] IOP_LDI  = 3'd5;
  localparam logic [2:0] IOP_HALT = 3'd7;

  typedef struct packed {
    logic writes_acc;  // ACC takes AluOut in EXEC
    logic is_mem;
    logic is_store;
    logic is_branch;   // taken only when AluBranch is set
    logic is_halt;
    logic reg_we;
  } dec_t;

endpackage

// File: rtl/acc_seq_decode.sv
// Combinational instruction classifier: turns the latched IR into the
// control flags the sequencer needs in EXEC and MEM.
module acc_seq_decode
  import acc_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output dec_t               dec_o
);

  logic [3:0] rop;
  logic [2:0] iop;

  assign rop = ir_i[7:4];
  assign iop = ir_i[7:5];

  always_comb begin
    dec_o = '0;
    if (ir_i[INSTR_W-1]) begin
      unique case (rop)
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOV, OP_CMP, OP_NOT:
          dec_o.writes_acc = 1'b1;
        OP_LOAD: dec_o.is_mem = 1'b1;
        OP_STR: begin
          dec_o.is_mem   = 1'b1;
          dec_o.is_store = 1'b1;
        end
        OP_MVFR: dec_o.reg_we    = 1'b1;
        OP_BTRU: dec_o.is_branch = 1'b1;
        default: ;
      endcase
    end else begin
      unique case (iop)
        IOP_ADDI, IOP_SUBI, IOP_ANDI, IOP_LDI: dec_o.writes_acc = 1'b1;
        IOP_B:    dec_o.is_branch = 1'b1;
        IOP_HALT: dec_o.is_halt   = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Fetch/decode/execute sequencer for the accumulator machine: owns PC, ACC and IR
// and drives the imem, regfile, dmem and ALU interfaces.
module acc_seq_ctrl
  import acc_pkg::*;
#(
  parameter int unsigned     PC_W   = 10,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  output logic               Done,
  output logic [PC_W-1:0]    Pc,
  output logic               ImemReq,
  input  logic               ImemValid,
  input  logic [INSTR_W-1:0] ImemData,
  output logic [3:0]         RegRdIdx,
  input  logic [7:0]         RegRdData,
  output logic               RegWe,
  output logic [7:0]         AccOut,
  output logic               AluType,
  output logic [3:0]         AluROp,
  output logic [2:0]         AluIOp,
  output logic [4:0]         AluImm,
  input  logic [7:0]         AluOut,
  input  logic               AluBranch,
  output logic               DmemReq,
  output logic               DmemWe,
  input  logic [7:0]         DmemRdata,
  input  logic               DmemAck
);

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [7:0]           acc_q, acc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic                 imem_req_q, dmem_req_q, dmem_we_q, reg_we_q, done_q;
  dec_t                 dec;
  logic [PC_W-1:0]      pc_inc, pc_rel, pc_reg;

  acc_seq_decode u_decode (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  assign pc_inc = pc_q + 1'b1;
  assign pc_rel = pc_q + {{(PC_W-5){ir_q[4]}}, ir_q[4:0]};
  assign pc_reg = PC_W'(RegRdData);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          state_d = FETCH;
          pc_d    = RST_PC;
        end
      end
      FETCH: begin
        if (ImemValid) begin
          ir_d    = ImemData;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        state_d = FETCH;
        pc_d    = pc_inc;
        if (dec.writes_acc) acc_d = AluOut;
        // Memory ops and HALT hold the PC; MEM advances it on completion
        if (dec.is_mem) begin
          state_d = MEM;
          pc_d    = pc_q;
        end else if (dec.is_halt) begin
          state_d = HALT;
          pc_d    = pc_q;
        end else if (dec.is_branch && AluBranch) begin
          pc_d = ir_q[INSTR_W-1] ? pc_reg : pc_rel;
        end
      end
      MEM: begin
        if (DmemAck) begin
          state_d = FETCH;
          pc_d    = pc_inc;
          if (!dec.is_store) acc_d = DmemRdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_q
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RST_PC;
      acc_q      <= '0;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      acc_q      <= acc_d;
      ir_q       <= ir_d;
      imem_req_q <= (state_d == FETCH);
      dmem_req_q <= (state_d == MEM);
      dmem_we_q  <= (state_d == MEM) && dec.is_store;
      reg_we_q   <= (state_d == EXEC) && dec.reg_we;
      done_q     <= (state_d == HALT);
    end
  end

  assign Done     = done_q;
  assign Pc       = pc_q;
  assign ImemReq  = imem_req_q;
  assign DmemReq  = dmem_req_q;
  assign DmemWe   = dmem_we_q;
  assign RegWe    = reg_we_q;
  assign AccOut   = acc_q;
  assign RegRdIdx = ir_q[3:0];
  assign AluType  = ir_q[INSTR_W-1];
  assign AluROp   = ir_q[7:4];
  assign AluIOp   = ir_q[7:5];
  assign AluImm   = ir_q[4:0];

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: behavioural imem/regfile/dmem/ALU around the DUT and an
// instruction-level reference model checked at every fetch and at HALT.
module tb_acc_seq_ctrl;

  localparam int MaxInstr = 60;
  localparam logic [8:0] IHalt = 9'h0E0;

  logic       Clk, Reset_n, Start, Done;
  logic [9:0] Pc;
  logic       ImemReq, ImemValid;
  logic [8:0] ImemData;
  logic [3:0] RegRdIdx;
  logic [7:0] RegRdData, AccOut, AluOut, DmemRdata;
  logic       RegWe, AluType, AluBranch, DmemReq, DmemWe, DmemAck;
  logic [3:0] AluROp;
  logic [2:0] AluIOp;
  logic [4:0] AluImm;

  logic [8:0] prog     [1024];
  logic [7:0] env_reg  [16];
  logic [7:0] env_dmem [256];
  logic [7:0] m_reg    [16];
  logic [7:0] m_dmem   [256];
  logic [7:0] m_acc;
  int         m_pc, m_mvfr, n_instr, n_regwe, last_dreq;
  int         fix_iw, fix_dw;
  bit         noise, br_noise, st_seen;
  logic [7:0] st_addr, st_data;
  int         checks = 0, errors = 0;

  acc_seq_ctrl #(.PC_W(10), .RST_PC(10'd0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Done(Done), .Pc(Pc),
    .ImemReq(ImemReq), .ImemValid(ImemValid), .ImemData(ImemData),
    .RegRdIdx(RegRdIdx), .RegRdData(RegRdData), .RegWe(RegWe), .AccOut(AccOut),
    .AluType(AluType), .AluROp(AluROp), .AluIOp(AluIOp), .AluImm(AluImm),
    .AluOut(AluOut), .AluBranch(AluBranch), .DmemReq(DmemReq), .DmemWe(DmemWe),
    .DmemRdata(DmemRdata), .DmemAck(DmemAck)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural ALU; non-writing ops return junk so stray ACC writes show up
  function automatic logic [7:0] alu_f(input logic t, input logic [3:0] rop,
                                       input logic [2:0] iop, input logic [4:0] imm,
                                       input logic [7:0] a, input logic [7:0] b);
    logic [7:0] ie;
    ie = {3'b000, imm};
    if (t) begin
      case (rop)
        4'd0:    return a + b;
        4'd3:    return a - b;
        4'd4:    return a & b;
        4'd5:    return a | b;
        4'd6:    return a ^ b;
        4'd7:    return a << 1;
        4'd9:    return a >> 1;
        4'd10:   return b;
        4'd12:   return (a == b) ? 8'd1 : 8'd0;
        4'd13:   return ~a;
        default: return a ^ 8'h5A;
      endcase
    end
    case (iop)
      3'd1:    return a + ie;
      3'd2:    return a - ie;
      3'd4:    return a & ie;
      3'd5:    return ie;
      default: return a ^ 8'hC3;
    endcase
  endfunction

  assign RegRdData = env_reg[RegRdIdx];
  assign AluOut    = alu_f(AluType, AluROp, AluIOp, AluImm, AccOut, RegRdData);
  assign AluBranch = AluType ? ((AluROp == 4'd11) ? (AccOut != 8'd0) : br_noise)
                             : ((AluIOp == 3'd3) ? 1'b1 : br_noise);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int fix);
    return (fix >= 0) ? fix : int'($urandom_range(3, 0));
  endfunction

  // Instruction-set reference: one whole instruction per call
  task automatic iss_step(input logic [8:0] ins);
    logic [7:0] opnd;
    int nxt, off;
    opnd = m_reg[ins[3:0]];
    nxt  = (m_pc + 1) % 1024;
    if (ins[8]) begin
      case (ins[7:4])
        4'd1:  m_acc = m_dmem[opnd];
        4'd2:  begin m_reg[ins[3:0]] = m_acc; m_mvfr++; end
        4'd8:  m_dmem[opnd] = m_acc;
        4'd11: if (m_acc != 8'd0) nxt = int'(opnd);
        4'd14, 4'd15: ;
        default: m_acc = alu_f(1'b1, ins[7:4], ins[7:5], ins[4:0], m_acc, opnd);
      endcase
    end else begin
      case (ins[7:5])
        3'd3: begin
          off = ins[4] ? int'(ins[4:0]) - 32 : int'(ins[4:0]);
          nxt = (m_pc + off + 1024) % 1024;
        end
        3'd7: nxt = m_pc;
        3'd0, 3'd6: ;
        default: m_acc = alu_f(1'b0, ins[7:4], ins[7:5], ins[4:0], m_acc, opnd);
      endcase
    end
    m_pc = nxt;
    n_instr++;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; Start = 1'b0; ImemValid = 1'b0; ImemData = '0;
    DmemAck = 1'b0; DmemRdata = '0; br_noise = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    m_acc = 8'd0;
    m_pc  = 0;
  endtask

  task automatic setup(input bit rnd);
    logic [8:0] ins;
    for (int i = 0; i < 1024; i++) begin
      ins = IHalt;
      if (rnd) begin
        do ins = 9'($urandom); while (ins[8] == 1'b0 && ins[7:5] == 3'd7);
      end
      prog[i] = ins;
    end
    for (int i = 0; i < 16; i++) begin
      env_reg[i] = rnd ? 8'($urandom) : 8'd0;
      m_reg[i]   = env_reg[i];
    end
    for (int i = 0; i < 256; i++) begin
      env_dmem[i] = rnd ? 8'($urandom) : 8'd0;
      m_dmem[i]   = env_dmem[i];
    end
  endtask

  task automatic set_reg(input int idx, input logic [7:0] v);
    env_reg[idx] = v;
    m_reg[idx]   = v;
  endtask

  task automatic set_dmem(input int idx, input logic [7:0] v);
    env_dmem[idx] = v;
    m_dmem[idx]   = v;
  endtask

  // Pulses Start and services the DUT until Done; cyc = edges after the Start edge
  task automatic run_prog(input int budget, output int cyc);
    int icnt, dcnt, iw, dw, run;
    bit fin;
    logic [8:0] ins;
    icnt = 0; dcnt = 0; run = 0; fin = 1'b0;
    iw = pick(fix_iw); dw = pick(fix_dw);
    m_pc = 0; n_instr = 0; m_mvfr = 0; n_regwe = 0; last_dreq = 0; st_seen = 1'b0;
    @(negedge Clk);
    Start = 1'b1;
    cyc = -1;
    while (!fin && cyc < budget) begin
      @(negedge Clk);
      cyc++;
      if (Done) begin
        fin = 1'b1; Start = 1'b0; ImemValid = 1'b0; DmemAck = 1'b0;
      end else begin
        Start    = noise && ($urandom_range(7, 0) == 0);
        br_noise = 1'($urandom_range(1, 0));
        if (RegWe) begin
          n_regwe++;
          env_reg[RegRdIdx] = AccOut;
        end
        if (DmemReq) run++;
        else begin
          if (run > 0) last_dreq = run;
          run = 0;
        end
        if (ImemReq) begin
          if (icnt >= iw) begin
            ins = (n_instr >= MaxInstr) ? IHalt : prog[m_pc];
            check_eq("fetch_pc", 32'(Pc), m_pc);
            check_eq("fetch_acc", 32'(AccOut), 32'(m_acc));
            iss_step(ins);
            ImemValid = 1'b1; ImemData = ins; icnt = 0; iw = pick(fix_iw);
          end else begin
            icnt++; ImemValid = 1'b0; ImemData = 9'($urandom);
          end
        end else begin
          ImemValid = noise && ($urandom_range(1, 0) == 1);
          ImemData  = 9'($urandom);
        end
        if (DmemReq) begin
          if (DmemWe) begin
            st_seen = 1'b1; st_addr = RegRdData; st_data = AccOut;
          end
          if (dcnt >= dw) begin
            DmemAck = 1'b1;
            if (DmemWe) env_dmem[RegRdData] = AccOut;
            DmemRdata = env_dmem[RegRdData];
            dcnt = 0; dw = pick(fix_dw);
          end else begin
            dcnt++; DmemAck = 1'b0; DmemRdata = 8'($urandom);
          end
        end else begin
          DmemAck   = noise && ($urandom_range(1, 0) == 1);
          DmemRdata = 8'($urandom);
        end
      end
    end
    check_eq("done_reached", 32'(fin), 1);
  endtask

  task automatic final_checks(input string tag);
    int bad;
    check_eq({tag, "_pc"}, 32'(Pc), m_pc);
    check_eq({tag, "_acc"}, 32'(AccOut), 32'(m_acc));
    for (int i = 0; i < 16; i++) check_eq({tag, "_reg"}, 32'(env_reg[i]), 32'(m_reg[i]));
    bad = 0;
    for (int i = 0; i < 256; i++) if (env_dmem[i] !== m_dmem[i]) bad++;
    check_eq({tag, "_dmem_bad"}, bad, 0);
    check_eq({tag, "_regwe"}, n_regwe, m_mvfr);
  endtask

  initial begin
    int cyc, k;
    noise = 1'b0; fix_iw = 0; fix_dw = 0;
    do_reset();
    check_eq("rst_pc", 32'(Pc), 0);
    check_eq("rst_acc", 32'(AccOut), 0);
    check_eq("rst_done", 32'(Done), 0);
    check_eq("rst_imemreq", 32'(ImemReq), 0);
    check_eq("rst_dmemreq", 32'(DmemReq), 0);
    check_eq("rst_regwe", 32'(RegWe), 0);
    check_eq("rst_alu", 32'({AluType, AluROp, AluImm}), 0);

    // ADDI 5; ADDI 3; HALT with zero-wait imem
    setup(1'b0);
    prog[0] = 9'h025; prog[1] = 9'h023; prog[2] = IHalt;
    run_prog(200, cyc);
    check_eq("addi_cycles", cyc, 9);
    check_eq("addi_acc", 32'(AccOut), 8);
    final_checks("addi");

    // Same program with 5-cycle imem latency, restarted from HALT
    fix_iw = 5;
    run_prog(400, cyc);
    check_eq("slowimem_cycles", cyc, 24);
    check_eq("slowimem_acc", 32'(AccOut), 16);
    fix_iw = 0;

    setup(1'b0); set_reg(2, 8'h20);
    prog[0] = 9'h0A1; prog[1] = 9'h1B2;
    run_prog(200, cyc);
    check_eq("btru_taken_pc", 32'(Pc), 32'h020);
    final_checks("btru_t");

    setup(1'b0); set_reg(2, 8'h20);
    prog[0] = 9'h0A0; prog[1] = 9'h1B2;
    run_prog(200, cyc);
    check_eq("btru_nt_pc", 32'(Pc), 2);

    setup(1'b0);
    prog[0] = 9'h07F;
    run_prog(200, cyc);
    check_eq("b_wrap_pc", 32'(Pc), 32'h3FF);

    setup(1'b0); set_reg(1, 8'h40); set_dmem(8'h40, 8'hA5);
    fix_dw = 3;
    prog[0] = 9'h111;
    run_prog(200, cyc);
    check_eq("load_req_len", last_dreq, 4);
    check_eq("load_acc", 32'(AccOut), 32'hA5);
    final_checks("load");

    setup(1'b0); set_reg(1, 8'h10); set_dmem(8'h10, 8'h7E); set_reg(4, 8'h33);
    fix_dw = 2;
    prog[0] = 9'h111; prog[1] = 9'h184;
    run_prog(200, cyc);
    check_eq("str_seen", 32'(st_seen), 1);
    check_eq("str_addr", 32'(st_addr), 32'h33);
    check_eq("str_data", 32'(st_data), 32'h7E);
    check_eq("str_mem", 32'(env_dmem[8'h33]), 32'h7E);
    check_eq("str_no_regwe", n_regwe, 0);

    noise = 1'b1; fix_iw = -1; fix_dw = -1;
    for (int r = 0; r < 6; r++) begin
      setup(1'b1);
      run_prog(3000, cyc);
      final_checks("rand");
    end

    // Reset while a load waits for its ack
    noise = 1'b0;
    do_reset();
    setup(1'b0); set_reg(1, 8'h40);
    prog[0] = 9'h025; prog[1] = 9'h111;
    @(negedge Clk); Start = 1'b1;
    @(negedge Clk); Start = 1'b0;
    k = 0;
    while (!DmemReq && k < 20) begin
      ImemValid = ImemReq; ImemData = prog[Pc];
      @(negedge Clk);
      k++;
    end
    ImemValid = 1'b0;
    check_eq("mrst_in_mem", 32'(DmemReq), 1);
    @(negedge Clk);
    check_eq("mrst_acc_before", 32'(AccOut), 5);
    Reset_n = 1'b0;
    #1;
    check_eq("mrst_dmemreq", 32'(DmemReq), 0);
    check_eq("mrst_imemreq", 32'(ImemReq), 0);
    check_eq("mrst_pc", 32'(Pc), 0);
    check_eq("mrst_acc", 32'(AccOut), 0);
    @(negedge Clk);
    Reset_n = 1'b1; DmemAck = 1'b1; DmemRdata = 8'hA5;
    @(negedge Clk);
    DmemAck = 1'b0;
    @(negedge Clk);
    check_eq("mrst_late_ack_acc", 32'(AccOut), 0);
    check_eq("mrst_idle_imem", 32'(ImemReq), 0);
    check_eq("mrst_idle_dmem", 32'(DmemReq), 0);
    check_eq("mrst_idle_done", 32'(Done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
